// File: rtl/puf_pkg.sv
// Shared constants and the verifier state encoding, common to the verifier and the PUF wrapper.
package puf_pkg;

    localparam int PUF_N       = 4;
    localparam int PUF_M       = 1;
    localparam int PUF_NUM_CRP = 16;
    localparam int PUF_SETTLE  = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_APPLY   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_SAMPLE  = 3'd3,
        ST_COMPARE = 3'd4,
        ST_FIN     = 3'd5
    } state_t;

    // Index width that stays legal for a single-entry table.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/puf_crp_mem.sv
// Enrolled challenge/response table: one synchronous write port, one combinational read port.
module puf_crp_mem
    import puf_pkg::*;
#(
    parameter int N       = PUF_N,
    parameter int M       = PUF_M,
    parameter int NUM_CRP = PUF_NUM_CRP,
    localparam int AW     = addr_width(NUM_CRP)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wchal,
    input  logic [M-1:0]  wresp,
    input  logic [AW-1:0] raddr,
    output logic [N-1:0]  rchal,
    output logic [M-1:0]  rresp
);

    logic [N-1:0] mem_chal [NUM_CRP];
    logic [M-1:0] mem_resp [NUM_CRP];

    // Contents are deliberately not reset; entries are meaningless until enrolled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_chal[waddr] <= wchal;
            mem_resp[waddr] <= wresp;
        end
    end

    assign rchal = mem_chal[raddr];
    assign rresp = mem_resp[raddr];

endmodule

// File: rtl/puf_crp_verifier.sv
// Walks every enrolled CRP, drives the challenge to the PUF, samples its synchronized
// response after a settle period and counts mismatches against the enrolled response.
module puf_crp_verifier
    import puf_pkg::*;
#(
    parameter int N       = PUF_N,
    parameter int M       = PUF_M,
    parameter int NUM_CRP = PUF_NUM_CRP,
    parameter int SETTLE  = PUF_SETTLE,
    parameter int ERR_W   = 5,
    parameter int MAX_ERR = 1,
    localparam int AW     = addr_width(NUM_CRP)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             crp_we,
    input  logic [AW-1:0]    crp_waddr,
    input  logic [N-1:0]     crp_wchal,
    input  logic [M-1:0]     crp_wresp,
    output logic [N-1:0]     challenge,
    input  logic [M-1:0]     puf_response,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [AW-1:0]    cur_idx
);

    localparam int SW = (SETTLE > 2) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]    SETTLE_INIT = SW'(SETTLE - 1);
    localparam logic [AW-1:0]    LAST_IDX    = AW'(NUM_CRP - 1);
    // A threshold at or above the counter ceiling means every run passes.
    localparam logic [ERR_W-1:0] MAX_ERR_C   =
        (MAX_ERR >= (2 ** ERR_W) - 1) ? {ERR_W{1'b1}} : ERR_W'(MAX_ERR);

    state_t         state_reg;
    logic [SW-1:0]  settle_reg;
    logic [M-1:0]   resp_q;
    logic [M-1:0]   sync_meta_reg;
    logic [M-1:0]   sync_reg;
    logic [N-1:0]   rd_chal;
    logic [M-1:0]   rd_resp;
    logic [M-1:0]   miss_bits;
    logic           mismatch;
    logic           err_ok;

    // Storage is frozen while a run is in progress.
    puf_crp_mem #(
        .N       (N),
        .M       (M),
        .NUM_CRP (NUM_CRP)
    ) u_mem (
        .clk   (clk),
        .we    (crp_we && !busy),
        .waddr (crp_waddr),
        .wchal (crp_wchal),
        .wresp (crp_wresp),
        .raddr (cur_idx),
        .rchal (rd_chal),
        .rresp (rd_resp)
    );

    // The PUF output is asynchronous to clk; its latency is counted inside SETTLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_reg <= '0;
            sync_reg      <= '0;
        end else begin
            sync_meta_reg <= puf_response;
            sync_reg      <= sync_meta_reg;
        end
    end

    for (genvar gi = 0; gi < M; gi++) begin : g_miss
        assign miss_bits[gi] = resp_q[gi] ^ rd_resp[gi];
    end

    assign mismatch = |miss_bits;
    assign err_ok   = (err_count <= MAX_ERR_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            settle_reg <= '0;
            resp_q     <= '0;
            challenge  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            cur_idx    <= '0;
        end else begin
            done <= 1'b0;
            if (abort && busy) begin
                // Cancelled run: no result, error count left for inspection.
                state_reg <= ST_IDLE;
                challenge <= '0;
                pass      <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start) begin
                            cur_idx   <= '0;
                            err_count <= '0;
                            pass      <= 1'b0;
                            busy      <= 1'b1;
                            state_reg <= ST_APPLY;
                        end
                    end
                    ST_APPLY: begin
                        challenge  <= rd_chal;
                        settle_reg <= SETTLE_INIT;
                        state_reg  <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (settle_reg == '0) begin
                            state_reg <= ST_SAMPLE;
                        end else begin
                            settle_reg <= settle_reg - 1'b1;
                        end
                    end
                    ST_SAMPLE: begin
                        resp_q    <= sync_reg;
                        state_reg <= ST_COMPARE;
                    end
                    ST_COMPARE: begin
                        if (mismatch && (err_count != {ERR_W{1'b1}})) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (cur_idx == LAST_IDX) begin
                            state_reg <= ST_FIN;
                        end else begin
                            cur_idx   <= cur_idx + 1'b1;
                            state_reg <= ST_APPLY;
                        end
                    end
                    ST_FIN: begin
                        done      <= 1'b1;
                        pass      <= err_ok;
                        busy      <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_puf_crp_verifier.sv
// Directed bench for the CRP verifier with a parity-function behavioural PUF.
module tb_puf_crp_verifier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start, abort, crp_we;
    logic [1:0] crp_waddr;
    logic [3:0] crp_wchal;
    logic [0:0] crp_wresp;
    logic [3:0] challenge;
    logic [0:0] puf_response;
    logic       busy, done, pass;
    logic [4:0] err_count;
    logic [1:0] cur_idx;

    logic       s_start, s_abort, s_crp_we;
    logic [2:0] s_crp_waddr;
    logic [3:0] s_crp_wchal;
    logic [0:0] s_crp_wresp;
    logic [3:0] s_challenge;
    logic [0:0] s_puf_response;
    logic       s_busy, s_done, s_pass;
    logic [1:0] s_err_count;
    logic [2:0] s_cur_idx;

    // Behavioural PUF: response is the parity of the challenge.
    assign puf_response   = ^challenge;
    assign s_puf_response = ^s_challenge;

    puf_crp_verifier #(
        .N(4), .M(1), .NUM_CRP(4), .SETTLE(3), .ERR_W(5), .MAX_ERR(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .crp_we(crp_we), .crp_waddr(crp_waddr), .crp_wchal(crp_wchal),
        .crp_wresp(crp_wresp), .challenge(challenge), .puf_response(puf_response),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .cur_idx(cur_idx)
    );

    puf_crp_verifier #(
        .N(4), .M(1), .NUM_CRP(8), .SETTLE(3), .ERR_W(2), .MAX_ERR(0)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
        .crp_we(s_crp_we), .crp_waddr(s_crp_waddr), .crp_wchal(s_crp_wchal),
        .crp_wresp(s_crp_wresp), .challenge(s_challenge), .puf_response(s_puf_response),
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err_count),
        .cur_idx(s_cur_idx)
    );

    int errors = 0;
    int checks = 0;

    // Enrolled table; responses are hand-computed parities (3->0, 7->1, A->0, E->1).
    logic [3:0] chal_tab [4] = '{4'h3, 4'h7, 4'hA, 4'hE};
    logic [0:0] resp_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] ch_seen  [4];
    int         lat;

    task automatic enroll(input logic [1:0] a, input logic [3:0] c, input logic [0:0] r);
        crp_we = 1'b1; crp_waddr = a; crp_wchal = c; crp_wresp = r;
        @(posedge clk); #1;
        crp_we = 1'b0;
    endtask

    // Starts a run, records the challenge after each APPLY edge, returns cycles to done (-1 on timeout).
    // At cycle inj_k a write to entry 0 and a second start are injected.
    task automatic run_to_done(input int inj_k, output int lat_o);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; crp_we = 1'b0;
        lat_o = -1;
        for (int k = 1; k <= 60; k++) begin
            if (k == inj_k) begin
                start = 1'b1; crp_we = 1'b1; crp_waddr = 2'd0;
                crp_wchal = 4'hF; crp_wresp = 1'b1;
            end
            @(posedge clk); #1;
            if (k == inj_k) begin
                start = 1'b0; crp_we = 1'b0;
            end
            if ((k % 6 == 1) && (k / 6 < 4)) ch_seen[k / 6] = challenge;
            if (done) begin
                lat_o = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 0; abort = 0; crp_we = 0; crp_waddr = 0; crp_wchal = 0; crp_wresp = 0;
        s_start = 0; s_abort = 0; s_crp_we = 0; s_crp_waddr = 0; s_crp_wchal = 0; s_crp_wresp = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (challenge !== 4'h0) begin errors++; $display("FAIL reset_challenge got=%h exp=0", challenge); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got=%b exp=0", pass); end
        checks++; if (err_count !== 5'd0) begin errors++; $display("FAIL reset_err got=%0d exp=0", err_count); end
        checks++; if (cur_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", cur_idx); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset: outputs checked, reset released");
    endtask

    task automatic test_nominal;
        for (int i = 0; i < 4; i++) enroll(2'(i), chal_tab[i], resp_tab[i]);
        run_to_done(0, lat);
        checks++; if (lat != 25) begin errors++; $display("FAIL nominal_latency got=%0d exp=25", lat); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL nominal_pass got=%b exp=1", pass); end
        checks++; if (err_count !== 5'd0) begin errors++; $display("FAIL nominal_err got=%0d exp=0", err_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nominal_busy got=%b exp=0", busy); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ch_seen[i] !== chal_tab[i]) begin
                errors++; $display("FAIL nominal_chal%0d got=%h exp=%h", i, ch_seen[i], chal_tab[i]);
            end
        end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL nominal_done_pulse got=%b exp=0", done); end
        checks++; if ({pass, cur_idx} !== {1'b1, 2'd3}) begin errors++; $display("FAIL nominal_hold got=%b/%0d exp=1/3", pass, cur_idx); end
        $display("nominal: latency=%0d pass=%b err=%0d", lat, pass, err_count);
    endtask

    task automatic test_mismatch;
        enroll(2'd2, 4'hA, 1'b1);
        run_to_done(0, lat);
        checks++; if (lat != 25) begin errors++; $display("FAIL mismatch_latency got=%0d exp=25", lat); end
        checks++; if (err_count !== 5'd1) begin errors++; $display("FAIL mismatch_err got=%0d exp=1", err_count); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL mismatch_pass got=%b exp=0", pass); end
        enroll(2'd2, 4'hA, 1'b0);
        $display("mismatch: latency=%0d pass=%b err=%0d", lat, pass, err_count);
    endtask

    task automatic test_write_start;
        crp_we = 1'b1; crp_waddr = 2'd0; crp_wchal = 4'h5; crp_wresp = 1'b0;
        run_to_done(0, lat);
        checks++; if (ch_seen[0] !== 4'h5) begin errors++; $display("FAIL write_start_chal got=%h exp=5", ch_seen[0]); end
        checks++; if ((lat != 25) || (pass !== 1'b1)) begin errors++; $display("FAIL write_start_run got=%0d/%b exp=25/1", lat, pass); end
        enroll(2'd0, 4'h3, 1'b0);
        $display("write_start: first challenge=%h pass=%b", ch_seen[0], pass);
    endtask

    task automatic test_abort;
        int done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
        end
        checks++; if ({busy, challenge} !== {1'b1, 4'h7}) begin errors++; $display("FAIL abort_pre got=%b/%h exp=1/7", busy, challenge); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (challenge !== 4'h0) begin errors++; $display("FAIL abort_challenge got=%h exp=0", challenge); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL abort_pass got=%b exp=0", pass); end
        checks++; if (cur_idx !== 2'd1) begin errors++; $display("FAIL abort_idx got=%0d exp=1", cur_idx); end
        done_cnt = (done === 1'b1) ? 1 : 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_cnt++;
        end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
        $display("abort: busy=%b challenge=%h done_pulses=%0d", busy, challenge, done_cnt);
    endtask

    task automatic test_busy_ignore;
        run_to_done(3, lat);
        checks++; if (lat != 25) begin errors++; $display("FAIL busy_ignore_latency got=%0d exp=25", lat); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL busy_ignore_pass got=%b exp=1", pass); end
        @(posedge clk); #1;
        run_to_done(0, lat);
        checks++; if (ch_seen[0] !== 4'h3) begin errors++; $display("FAIL busy_ignore_storage got=%h exp=3", ch_seen[0]); end
        checks++; if ((lat != 25) || (pass !== 1'b1)) begin errors++; $display("FAIL busy_ignore_rerun got=%0d/%b exp=25/1", lat, pass); end
        $display("busy_ignore: latency=%0d entry0=%h pass=%b", lat, ch_seen[0], pass);
    endtask

    task automatic test_async_reset;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b exp=0", busy); end
        checks++; if (challenge !== 4'h0) begin errors++; $display("FAIL areset_challenge got=%h exp=0", challenge); end
        checks++; if (cur_idx !== 2'd0) begin errors++; $display("FAIL areset_idx got=%0d exp=0", cur_idx); end
        checks++; if ({done, pass, err_count} !== 7'd0) begin errors++; $display("FAIL areset_flags got=%b/%b/%0d exp=0/0/0", done, pass, err_count); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_to_done(0, lat);
        checks++; if (lat != 25) begin errors++; $display("FAIL areset_rerun_latency got=%0d exp=25", lat); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL areset_rerun_pass got=%b exp=1", pass); end
        $display("async_reset: rerun latency=%0d pass=%b", lat, pass);
    endtask

    task automatic test_saturate;
        int s_lat;
        for (int i = 0; i < 8; i++) begin
            s_crp_we = 1'b1; s_crp_waddr = 3'(i); s_crp_wchal = 4'(i + 1);
            s_crp_wresp = ~(^s_crp_wchal);
            @(posedge clk); #1;
        end
        s_crp_we = 1'b0;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        s_lat = -1;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (s_done) begin
                s_lat = k;
                break;
            end
        end
        checks++; if (s_lat != 49) begin errors++; $display("FAIL saturate_latency got=%0d exp=49", s_lat); end
        checks++; if (s_err_count !== 2'd3) begin errors++; $display("FAIL saturate_err got=%0d exp=3", s_err_count); end
        checks++; if (s_pass !== 1'b0) begin errors++; $display("FAIL saturate_pass got=%b exp=0", s_pass); end
        $display("saturate: latency=%0d err=%0d pass=%b", s_lat, s_err_count, s_pass);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_mismatch();
        test_write_start();
        test_abort();
        test_busy_ignore();
        test_async_reset();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/puf_crp_verifier.md
PUF_CRP_VERIFIER -- requirements
Module: puf_crp_verifier

Interface
REQ-001 The block SHALL have the parameter N, default 4: challenge width in bits.
REQ-002 The block SHALL have the parameter M, default 1: response width in bits.
REQ-003 The block SHALL have the parameter NUM_CRP, default 16: number of enrolled challenge-response pairs (CRPs).
REQ-004 The block SHALL have the parameter SETTLE, default 4, minimum 3: cycles waited after a challenge is applied before the response is sampled.
REQ-005 The block SHALL have the parameter ERR_W, default 5: width of the error counter.
REQ-006 The block SHALL have the parameter MAX_ERR, default 1: highest error count that still passes.
REQ-007 The block SHALL have one clock and an asynchronous active-low reset; ports are listed below (name, direction, width, meaning).
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse that starts an authentication run.
- abort  in  1  pulse that cancels a run in progress.
- crp_we  in  1  enrollment write strobe.
- crp_waddr  in  clog2(NUM_CRP)  enrollment entry index.
- crp_wchal  in  N  enrolled challenge.
- crp_wresp  in  M  expected response.
- challenge  out  N  registered challenge driven to the PUF.
- puf_response  in  M  raw, asynchronous PUF response.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse at the end of a run.
- pass  out  1  result of the last completed run.
- err_count  out  ERR_W  mismatching entries in the current or last run.
- cur_idx  out  clog2(NUM_CRP)  entry currently under test.

Function
REQ-008 The block SHALL implement the states IDLE, APPLY, WAIT, SAMPLE, COMPARE and FIN.
REQ-009 In IDLE, start SHALL: clear cur_idx and err_count, clear pass, and move to APPLY; busy SHALL be high from the next cycle.
REQ-010 In APPLY, the block SHALL: drive challenge with mem_chal[cur_idx], load the settle counter with SETTLE-1, and move to WAIT.
REQ-011 In WAIT, the block SHALL decrement the settle counter and move to SAMPLE on the cycle the counter reads 0.
REQ-012 puf_response SHALL pass through a 2-flop synchronizer at all times; SETTLE includes the synchronizer latency.
REQ-013 In SAMPLE, the block SHALL capture the synchronized response into resp_q.
REQ-014 In COMPARE, if resp_q differs from mem_resp[cur_idx] in any bit, the block SHALL increment err_count; err_count SHALL saturate at 2^ERR_W-1.
REQ-015 In COMPARE, if cur_idx equals NUM_CRP-1 the block SHALL move to FIN; otherwise it SHALL increment cur_idx and move to APPLY.
REQ-016 In FIN, the block SHALL: pulse done for one cycle, set pass to 1 when err_count <= MAX_ERR, deassert busy, and return to IDLE.
REQ-017 Each entry SHALL take exactly SETTLE+3 cycles; done SHALL assert NUM_CRP*(SETTLE+3)+1 cycles after the start cycle.
REQ-018 start SHALL be ignored while busy is high.
REQ-019 crp_we SHALL write both arrays at crp_waddr when busy is low and SHALL be ignored when busy is high.
REQ-020 When start and crp_we arrive in the same IDLE cycle, the write SHALL complete and the first APPLY SHALL read the new value.
REQ-021 abort while busy SHALL return the FSM to IDLE on the next edge, with challenge set to 0, pass set to 0, no done pulse, and err_count held.
REQ-022 pass, err_count and cur_idx SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-023 rst_n low SHALL immediately force the state to IDLE and set challenge, busy, done, pass, err_count, cur_idx, resp_q and the synchronizer to 0, including in the middle of a run.
REQ-024 CRP storage SHALL NOT be reset; its contents are undefined until enrolled.
REQ-025 Release of reset SHALL require no start pulse in the same cycle to be honoured; the first start is accepted one cycle after release.

Structure
REQ-026 Package puf_pkg SHALL hold the state enum and the default N, M, NUM_CRP and SETTLE constants, shared with the PUF.
REQ-027 CRP storage SHALL be the sub-module puf_crp_mem, with one synchronous write port and one asynchronous read port.
REQ-028 The FSM, counters and synchronizer SHALL reside in puf_crp_verifier.

Verification
All scenarios use N=4, M=1, NUM_CRP=4, SETTLE=3, MAX_ERR=0 unless noted.
REQ-029 Enroll 4 CRPs matching a behavioural PUF, then pulse start -> done at +25 cycles, pass=1, err_count=0, and challenge sequence matches the enrolled order.
REQ-030 Enroll entry 2 with an inverted response -> err_count=1 and pass=0 at done.
REQ-031 Pulse abort during entry 1 WAIT -> busy=0 and challenge=0 on the next cycle, no done pulse, pass=0.
REQ-032 Drive rst_n low mid-run, asynchronous to clk -> all outputs 0 before the next edge; a later start runs a full 25-cycle pass.
REQ-033 With ERR_W=2 and NUM_CRP=8, all entries wrong -> err_count saturates at 3 and pass=0.
REQ-034 Apply crp_we and start while busy -> storage unchanged and the run is not restarted (done timing as in REQ-029).
